// File: rtl/spi_seq_pkg.sv
// Shared codes, FSM state encoding and command record for the SPI transaction sequencer.
package spi_seq_pkg;

    localparam logic [1:0] CS_IDLE = 2'b00;
    localparam logic [1:0] CS_S1   = 2'b01;
    localparam logic [1:0] CS_S2   = 2'b10;
    localparam logic [1:0] CS_S3   = 2'b11;

    localparam logic [1:0] RW_NOP  = 2'b00;
    localparam logic [1:0] RW_WR   = 2'b01;
    localparam logic [1:0] RW_RD   = 2'b10;
    localparam logic [1:0] RW_WRRD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_XFER,
        ST_CAPTURE,
        ST_RSP_WAIT,
        ST_DONE,
        ST_GAP
    } state_t;

    typedef struct packed {
        logic [1:0] cs;
        logic [1:0] rw;
        logic [1:0] mode;
        logic [7:0] wdata;
    } cmd_t;

endpackage

// File: rtl/spi_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO of cmd_t records; DEPTH must be a power of 2.
module spi_cmd_fifo
    import spi_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  cmd_t                     wr_data,
    input  logic                     pop,
    output cmd_t                     rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    cmd_t           mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage carries no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Buffers SPI byte commands and replays each as a paced CS/RW/MODE/data window, capturing read data.
// Optional SPI_SEQ_GAP_EN adds a GAP state holding CS idle for GAP_CYCLES between transfers.
module spi_txn_sequencer
    import spi_seq_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int XFER_CYCLES = 32,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_cs,
    input  logic [1:0]               cmd_rw,
    input  logic [1:0]               cmd_mode,
    input  logic [7:0]               cmd_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [7:0]               rsp_rdata,
    output logic [1:0]               rsp_cs,
    output logic [7:0]               spi_data_in,
    input  logic [7:0]               spi_data_out,
    output logic [1:0]               spi_cs,
    output logic [1:0]               spi_rw,
    output logic [1:0]               spi_mode,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int CNT_MAX = (XFER_CYCLES > GAP_CYCLES) ? XFER_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    cmd_t              wr_cmd;
    cmd_t              head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;

    assign wr_cmd    = '{cs: cmd_cs, rw: cmd_rw, mode: cmd_mode, wdata: cmd_wdata};
    assign cmd_ready = !fifo_full;
    assign pop       = (state == ST_IDLE) && !fifo_empty;
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    spi_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (cmd_valid),
        .wr_data (wr_cmd),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // The SPI word is registered on the pop edge so CS goes inactive only for DONE+IDLE
    // between back-to-back transfers; LOAD is the first cycle of the stable window.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            spi_cs      <= CS_IDLE;
            spi_rw      <= RW_NOP;
            spi_mode    <= 2'b00;
            spi_data_in <= 8'h00;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 8'h00;
            rsp_cs      <= CS_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty && head.cs != CS_IDLE && head.rw != RW_NOP) begin
                        spi_cs      <= head.cs;
                        spi_rw      <= head.rw;
                        spi_mode    <= head.mode;
                        spi_data_in <= head.wdata;
                        state       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cnt   <= '0;
                    state <= ST_XFER;
                end
                ST_XFER: begin
                    if (cnt == CNT_W'(XFER_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= ST_CAPTURE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    spi_cs <= CS_IDLE;
                    spi_rw <= RW_NOP;
                    if (spi_rw[1]) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= spi_data_out;
                        rsp_cs    <= spi_cs;
                        state     <= ST_RSP_WAIT;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_RSP_WAIT: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
`ifdef SPI_SEQ_GAP_EN
                    cnt   <= '0;
                    state <= ST_GAP;
`else
                    state <= ST_IDLE;
`endif
                end
`ifdef SPI_SEQ_GAP_EN
                ST_GAP: begin
                    if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed bench for spi_txn_sequencer: vector table for single commands plus multi-cycle sequences.
module tb_spi_txn_sequencer;

    localparam int DEPTH = 4;
    localparam int XC    = 16;
    localparam int GC    = 3;
`ifdef SPI_SEQ_GAP_EN
    localparam int EXP_GAP = 2 + GC;
`else
    localparam int EXP_GAP = 2;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_cs;
    logic [1:0]  cmd_rw;
    logic [1:0]  cmd_mode;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_rdata;
    logic [1:0]  rsp_cs;
    logic [7:0]  spi_data_in;
    logic [7:0]  spi_data_out;
    logic [1:0]  spi_cs;
    logic [1:0]  spi_rw;
    logic [1:0]  spi_mode;
    logic        busy;
    logic [$clog2(DEPTH):0] fifo_level;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    spi_txn_sequencer #(
        .DEPTH       (DEPTH),
        .XFER_CYCLES (XC),
        .GAP_CYCLES  (GC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_cs       (cmd_cs),
        .cmd_rw       (cmd_rw),
        .cmd_mode     (cmd_mode),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_cs       (rsp_cs),
        .spi_data_in  (spi_data_in),
        .spi_data_out (spi_data_out),
        .spi_cs       (spi_cs),
        .spi_rw       (spi_rw),
        .spi_mode     (spi_mode),
        .busy         (busy),
        .fifo_level   (fifo_level)
    );

    typedef struct {
        logic [1:0] cs;
        logic [1:0] rw;
        logic [1:0] mode;
        logic [7:0] wdata;
        logic [7:0] sdo;
        bit         exp_act;
        bit         exp_rsp;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_cmd(input logic [1:0] cs, input logic [1:0] rw,
                           input logic [1:0] mode, input logic [7:0] wdata);
        cmd_cs    = cs;
        cmd_rw    = rw;
        cmd_mode  = mode;
        cmd_wdata = wdata;
    endtask

    initial begin
        int act_n, rsp_n, t_a, t_r, unstable, phase, zeros, seen;
        bit done, accepted;
        logic [1:0] s_cs, s_rw, s_mode, r_cs, prev_cs;
        logic [7:0] s_din, r_d;
        logic [7:0] order [$];

        vecs[0] = '{2'b01, 2'b01, 2'b00, 8'hA5, 8'h00, 1'b1, 1'b0, 8'h00};
        vecs[1] = '{2'b10, 2'b10, 2'b01, 8'h00, 8'h3C, 1'b1, 1'b1, 8'h3C};
        vecs[2] = '{2'b00, 2'b10, 2'b00, 8'h11, 8'h99, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{2'b11, 2'b00, 2'b00, 8'h22, 8'h99, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{2'b11, 2'b11, 2'b11, 8'h5A, 8'hC3, 1'b1, 1'b1, 8'hC3};
        vecs[5] = '{2'b01, 2'b11, 2'b10, 8'hFF, 8'h00, 1'b1, 1'b1, 8'h00};

        reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; spi_data_out = 8'h00;
        set_cmd(2'b00, 2'b00, 2'b00, 8'h00);
        repeat (3) tick();
        reset = 1'b0;
        check("rst cmd_ready", cmd_ready, 1);
        check("rst spi_cs", spi_cs, 0);
        check("rst spi_rw", spi_rw, 0);
        check("rst rsp_valid", rsp_valid, 0);
        check("rst busy", busy, 0);
        check("rst fifo_level", fifo_level, 0);
        check("rst spi_data_in", spi_data_in, 0);

        // Single commands from an idle, empty sequencer.
        for (int v = 0; v < 6; v++) begin
            set_cmd(vecs[v].cs, vecs[v].rw, vecs[v].mode, vecs[v].wdata);
            spi_data_out = vecs[v].sdo;
            rsp_ready = 1'b1;
            cmd_valid = 1'b1;
            tick();
            cmd_valid = 1'b0;
            act_n = 0; rsp_n = 0; t_a = -1; t_r = -1; unstable = 0; done = 1'b0;
            s_cs = '0; s_rw = '0; s_mode = '0; s_din = '0; r_d = '0; r_cs = '0;
            for (int t = 0; t < 200 && !done; t++) begin
                tick();
                if (spi_cs != 2'b00) begin
                    if (act_n == 0) begin
                        t_a = t; s_cs = spi_cs; s_rw = spi_rw; s_mode = spi_mode; s_din = spi_data_in;
                    end else if ({spi_cs, spi_rw, spi_mode, spi_data_in} != {s_cs, s_rw, s_mode, s_din}) begin
                        unstable++;
                    end
                    act_n++;
                end
                if (rsp_valid) begin
                    if (rsp_n == 0) begin
                        t_r = t; r_d = rsp_rdata; r_cs = rsp_cs;
                    end
                    rsp_n++;
                end
                if (!busy && !rsp_valid) done = 1'b1;
            end
            check($sformatf("v%0d finished", v), done, 1);
            check($sformatf("v%0d active cycles", v), act_n, vecs[v].exp_act ? XC + 2 : 0);
            check($sformatf("v%0d rsp cycles", v), rsp_n, vecs[v].exp_rsp ? 1 : 0);
            if (vecs[v].exp_act) begin
                check($sformatf("v%0d spi_cs", v), s_cs, vecs[v].cs);
                check($sformatf("v%0d spi_rw", v), s_rw, vecs[v].rw);
                check($sformatf("v%0d spi_mode", v), s_mode, vecs[v].mode);
                check($sformatf("v%0d spi_data_in", v), s_din, vecs[v].wdata);
                check($sformatf("v%0d stable", v), unstable, 0);
            end
            if (vecs[v].exp_rsp) begin
                check($sformatf("v%0d rsp_rdata", v), r_d, vecs[v].exp_rdata);
                check($sformatf("v%0d rsp_cs", v), r_cs, vecs[v].cs);
                check($sformatf("v%0d rsp latency", v), t_r - t_a, XC + 2);
            end
        end

        // Stall in RSP_WAIT, fill the FIFO, then drain and verify order.
        rsp_ready = 1'b0;
        spi_data_out = 8'h11;
        set_cmd(2'b01, 2'b10, 2'b00, 8'h00);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        seen = 0;
        for (int t = 0; t < 200 && !rsp_valid; t++) tick();
        check("stall rsp_valid", rsp_valid, 1);
        for (int i = 0; i < 4; i++) begin
            set_cmd(2'b10, 2'b01, 2'b00, 8'h10 + 8'(i));
            cmd_valid = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        check("full cmd_ready", cmd_ready, 0);
        check("full fifo_level", fifo_level, 4);
        set_cmd(2'b10, 2'b01, 2'b00, 8'h14);
        cmd_valid = 1'b1;
        repeat (3) tick();
        check("full still blocked", cmd_ready, 0);
        check("stall rsp held", rsp_valid, 1);
        check("stall rsp_rdata", rsp_rdata, 8'h11);
        rsp_ready = 1'b1;
        accepted = 1'b0;
        prev_cs = 2'b00;
        order.delete();
        for (int t = 0; t < 600 && !(accepted && !busy); t++) begin
            if (cmd_valid && cmd_ready) accepted = 1'b1;
            tick();
            if (accepted) cmd_valid = 1'b0;
            if (prev_cs == 2'b00 && spi_cs != 2'b00) order.push_back(spi_data_in);
            prev_cs = spi_cs;
        end
        cmd_valid = 1'b0;
        check("drain accepted 5th", accepted, 1);
        check("drain count", order.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < order.size()) check($sformatf("drain order %0d", i), order[i], 8'h10 + 8'(i));
            else check($sformatf("drain order %0d", i), 8'hxx, 8'h10 + 8'(i));
        end

        // Reset in the middle of a transfer with two commands queued.
        spi_data_out = 8'h77;
        for (int i = 0; i < 3; i++) begin
            set_cmd(2'b10, 2'b11, 2'b01, 8'h70 + 8'(i));
            cmd_valid = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        for (int t = 0; t < 50 && spi_cs == 2'b00; t++) tick();
        repeat (10) tick();
        check("pre-reset spi_cs", spi_cs, 2'b10);
        check("pre-reset fifo_level", fifo_level, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid-reset spi_cs", spi_cs, 0);
        check("mid-reset fifo_level", fifo_level, 0);
        check("mid-reset rsp_valid", rsp_valid, 0);
        check("mid-reset cmd_ready", cmd_ready, 1);
        repeat (XC + 6) tick();
        check("post-reset no rsp", rsp_valid, 0);
        check("post-reset idle", busy, 0);

        // Back-to-back writes: measure the CS-idle span between them.
        set_cmd(2'b01, 2'b01, 2'b00, 8'hA1);
        cmd_valid = 1'b1;
        tick();
        set_cmd(2'b10, 2'b01, 2'b00, 8'hB2);
        tick();
        cmd_valid = 1'b0;
        phase = 0; zeros = 0;
        for (int t = 0; t < 300 && phase < 3; t++) begin
            tick();
            case (phase)
                0: if (spi_cs != 2'b00) phase = 1;
                1: if (spi_cs == 2'b00) begin phase = 2; zeros = 1; end
                2: if (spi_cs != 2'b00) phase = 3; else zeros++;
                default: ;
            endcase
        end
        check("gap reached 2nd xfer", phase, 3);
        check("gap span", zeros, EXP_GAP);
        check("gap 2nd spi_cs", spi_cs, 2'b10);
        check("gap 2nd data_in", spi_data_in, 8'hB2);
        for (int t = 0; t < 200 && busy; t++) tick();
        check("gap finish idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
